// File: rtl/alu_sequencer_if.sv
// Host-side command/response handshake bundle for the ALU sequencer.
// master = host/test controller, slave = sequencer.
interface alu_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_cin;
   logic             cmd_clr;
   logic [CNT_W-1:0] cmd_len;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_cout;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_clr, cmd_len, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_cout
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_clr, cmd_len, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_cout
   );
endinterface

// File: rtl/alu_sequencer.sv
// Command-side initiator for the 8-bit ALU: accepts one op, sequences the
// ALU pins cycle by cycle, captures f/cout and returns them to the host.
module alu_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   alu_sequencer_if.slave   bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_L,
   output logic             alu_En,
   output logic             alu_reset,
   output logic [1:0]       alu_s,
   input  logic [WIDTH-1:0] alu_f,
   input  logic             alu_cout,
   output logic             busy
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CLEAR   = 3'd1;
   localparam logic [2:0] LOAD    = 3'd2;
   localparam logic [2:0] RUN     = 3'd3;
   localparam logic [2:0] CAPTURE = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SHIFT = 2'b01;
   localparam logic [1:0] OP_COUNT = 2'b10;

   logic [2:0]       state, state_nx;
   logic [1:0]       op_q, op_cur;
   logic             cin_q, cin_cur;
   logic [CNT_W-1:0] cnt;
   logic             accept, len_zero;
   logic             l_nx, en_nx;
   logic             rsp_valid_q, rsp_cout_q;
   logic [WIDTH-1:0] rsp_data_q;

   assign accept    = bus.cmd_valid && (state == IDLE);
   assign op_cur    = (state == IDLE) ? bus.cmd_op  : op_q;
   assign cin_cur   = (state == IDLE) ? bus.cmd_cin : cin_q;
   // cnt is loaded with cmd_len on acceptance, so it still equals the length until RUN
   assign len_zero  = (state == IDLE) ? (bus.cmd_len == '0) : (cnt == '0);

   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign alu_reset     = reset && (state != CLEAR);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (bus.cmd_op)
                  OP_COUNT: state_nx = bus.cmd_clr ? CLEAR : LOAD;
                  OP_SHIFT: state_nx = bus.cmd_clr ? CLEAR : (len_zero ? CAPTURE : RUN);
                  default:  state_nx = CAPTURE;
               endcase
            end
         end
         CLEAR:   state_nx = (op_q == OP_COUNT) ? LOAD : (len_zero ? CAPTURE : RUN);
         LOAD:    state_nx = len_zero ? CAPTURE : RUN;
         RUN:     state_nx = (cnt == CNT_W'(1)) ? CAPTURE : RUN;
         CAPTURE: state_nx = RESP;
         RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   // ALU control pins are registered from the next state so they line up with it
   always_comb begin
      l_nx  = 1'b0;
      en_nx = 1'b0;
      case (state_nx)
         LOAD: begin
            l_nx  = 1'b1;
            en_nx = 1'b1;
         end
         RUN:     en_nx = (op_cur == OP_COUNT);
         CAPTURE: l_nx  = (op_cur == OP_ADD) && cin_cur;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         op_q        <= '0;
         cin_q       <= 1'b0;
         cnt         <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_s       <= '0;
         alu_L       <= 1'b0;
         alu_En      <= 1'b0;
         busy        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         alu_L  <= l_nx;
         alu_En <= en_nx;
         busy   <= (state_nx != IDLE);
         if (accept) begin
            op_q  <= bus.cmd_op;
            cin_q <= bus.cmd_cin;
            cnt   <= bus.cmd_len;
            alu_a <= bus.cmd_a;
            alu_b <= bus.cmd_b;
            alu_s <= bus.cmd_op;
         end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (state == CAPTURE) begin
            rsp_data_q  <= alu_f;
            rsp_cout_q  <= (op_q == OP_ADD) ? alu_cout : 1'b0;
            rsp_valid_q <= 1'b1;
         end else if (state == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU attached
// (add, serial shift-left of a[0], loadable up-counter, xor).
module tb_alu_sequencer;
   logic       clk;
   logic       rst_n;
   logic [7:0] alu_a, alu_b, alu_f;
   logic       alu_L, alu_En, alu_reset, alu_cout, busy;
   logic [1:0] alu_s;
   logic [7:0] q;

   int unsigned applied    = 0;
   int unsigned miscompares = 0;

   alu_sequencer_if #(.WIDTH(8), .CNT_W(8)) bus ();

   alu_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
      .clock     (clk),
      .reset     (rst_n),
      .bus       (bus),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_L     (alu_L),
      .alu_En    (alu_En),
      .alu_reset (alu_reset),
      .alu_s     (alu_s),
      .alu_f     (alu_f),
      .alu_cout  (alu_cout),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_ff @(posedge clk or negedge alu_reset) begin
      if (!alu_reset) q <= '0;
      else if (alu_s == 2'b10) begin
         if (alu_L && alu_En) q <= alu_a;
         else if (alu_En)     q <= q + 8'd1;
      end else if (alu_s == 2'b01 && !alu_En) begin
         q <= {q[6:0], alu_a[0]};
      end
   end

   always_comb begin
      {alu_cout, alu_f} = {1'b0, q};
      alu_cout          = q[7];
      case (alu_s)
         2'b00:   {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_L};
         2'b11:   {alu_cout, alu_f} = {1'b0, alu_a ^ alu_b};
         default: ;
      endcase
   end

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a, b;
      logic        cin, clr;
      logic [7:0]  len;
      logic [7:0]  data;
      logic        cout;
      int unsigned lat, nrst, nl, nen;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input vec_t v, output logic [7:0] d, output logic c,
                          output int unsigned lat, output int unsigned nrst,
                          output int unsigned nl, output int unsigned nen, output logic s_ok);
      bus.cmd_op    = v.op;
      bus.cmd_a     = v.a;
      bus.cmd_b     = v.b;
      bus.cmd_cin   = v.cin;
      bus.cmd_clr   = v.clr;
      bus.cmd_len   = v.len;
      bus.cmd_valid = 1'b1;
      lat = 0; nrst = 0; nl = 0; nen = 0; s_ok = 1'b1;
      do begin
         @(posedge clk); #1;
         bus.cmd_valid = 1'b0;
         lat++;
         if (!alu_reset)     nrst++;
         if (alu_L)          nl++;
         if (alu_En)         nen++;
         if (alu_s !== v.op) s_ok = 1'b0;
      end while (!bus.rsp_valid && lat < 100);
      d = bus.rsp_data;
      c = bus.rsp_cout;
   endtask

   task automatic ack();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      logic [7:0]  d;
      logic        c, s_ok, stable, rdy_ok;
      int unsigned lat, nrst, nl, nen;
      vec_t        v;

      //           op     a      b      cin   clr   len   data   cout lat rst L  En
      tbl[0]  = '{2'b00, 8'hF0, 8'h20, 1'b1, 1'b0, 8'd0, 8'h11, 1'b1, 2, 0, 1, 0};
      tbl[1]  = '{2'b00, 8'h7F, 8'h01, 1'b0, 1'b0, 8'd0, 8'h80, 1'b0, 2, 0, 0, 0};
      tbl[2]  = '{2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'd0, 8'hFF, 1'b1, 2, 0, 1, 0};
      tbl[3]  = '{2'b11, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'd0, 8'h99, 1'b0, 2, 0, 0, 0};
      tbl[4]  = '{2'b10, 8'hFE, 8'h00, 1'b0, 1'b1, 8'd5, 8'h03, 1'b0, 9, 1, 1, 6};
      tbl[5]  = '{2'b10, 8'h5A, 8'h00, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b0, 3, 0, 1, 1};
      tbl[6]  = '{2'b10, 8'h10, 8'h00, 1'b0, 1'b0, 8'd3, 8'h13, 1'b0, 6, 0, 1, 4};
      tbl[7]  = '{2'b10, 8'hF0, 8'h00, 1'b0, 1'b1, 8'd2, 8'hF2, 1'b0, 6, 1, 1, 3};
      tbl[8]  = '{2'b01, 8'h01, 8'h00, 1'b0, 1'b1, 8'd4, 8'h0F, 1'b0, 7, 1, 0, 0};
      tbl[9]  = '{2'b01, 8'h01, 8'h00, 1'b0, 1'b1, 8'd8, 8'hFF, 1'b0, 11, 1, 0, 0};
      tbl[10] = '{2'b01, 8'h01, 8'h00, 1'b0, 1'b1, 8'd0, 8'h00, 1'b0, 3, 1, 0, 0};

      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
      bus.cmd_cin = 1'b0; bus.cmd_clr = 1'b0; bus.cmd_len = '0; bus.rsp_ready = 1'b0;
      #2;
      check("rst alu_a", {24'd0, alu_a}, 32'h0);
      check("rst alu_En/L", {30'd0, alu_En, alu_L}, 32'h0);
      check("rst alu_s", {30'd0, alu_s}, 32'h0);
      check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
      check("rst busy", {31'd0, busy}, 32'h0);
      check("rst alu_reset", {31'd0, alu_reset}, 32'h0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-rst cmd_ready", {31'd0, bus.cmd_ready}, 32'h1);
      check("post-rst alu_reset", {31'd0, alu_reset}, 32'h1);

      for (int i = 0; i < 11; i++) begin
         run_cmd(tbl[i], d, c, lat, nrst, nl, nen, s_ok);
         check($sformatf("v%0d data", i), {24'd0, d}, {24'd0, tbl[i].data});
         check($sformatf("v%0d cout", i), {31'd0, c}, {31'd0, tbl[i].cout});
         check($sformatf("v%0d latency", i), lat, tbl[i].lat);
         check($sformatf("v%0d alu_reset low cycles", i), nrst, tbl[i].nrst);
         check($sformatf("v%0d alu_L high cycles", i), nl, tbl[i].nl);
         check($sformatf("v%0d alu_En high cycles", i), nen, tbl[i].nen);
         check($sformatf("v%0d alu_s held", i), {31'd0, s_ok}, 32'h1);
         ack();
         check($sformatf("v%0d rsp_valid after ack", i), {31'd0, bus.rsp_valid}, 32'h0);
      end

      // Back-pressure: response held, a second command must be ignored
      v = '{2'b00, 8'h12, 8'h34, 1'b0, 1'b0, 8'd0, 8'h46, 1'b0, 2, 0, 0, 0};
      run_cmd(v, d, c, lat, nrst, nl, nen, s_ok);
      check("bp data", {24'd0, d}, 32'h46);
      check("bp latency", lat, 32'd2);
      bus.cmd_op = 2'b10; bus.cmd_a = 8'hAA; bus.cmd_len = 8'd3; bus.cmd_valid = 1'b1;
      stable = 1'b1; rdy_ok = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (!bus.rsp_valid || bus.rsp_data !== 8'h46 || bus.rsp_cout !== 1'b0) stable = 1'b0;
         if (bus.cmd_ready) rdy_ok = 1'b0;
      end
      bus.cmd_valid = 1'b0;
      check("bp rsp stable", {31'd0, stable}, 32'h1);
      check("bp cmd_ready low", {31'd0, rdy_ok}, 32'h1);
      ack();
      check("bp released rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
      check("bp released cmd_ready", {31'd0, bus.cmd_ready}, 32'h1);
      check("bp released busy", {31'd0, busy}, 32'h0);
      v = '{2'b11, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'd0, 8'hFF, 1'b0, 2, 0, 0, 0};
      run_cmd(v, d, c, lat, nrst, nl, nen, s_ok);
      check("bp next data", {24'd0, d}, 32'hFF);
      check("bp next latency", lat, 32'd2);
      ack();

      // Asynchronous reset in the middle of a long count
      bus.cmd_op = 2'b10; bus.cmd_a = 8'h00; bus.cmd_clr = 1'b0; bus.cmd_len = 8'd20;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #4 rst_n = 1'b0;
      #1;
      check("arst busy", {31'd0, busy}, 32'h0);
      check("arst rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
      check("arst alu_reset", {31'd0, alu_reset}, 32'h0);
      check("arst alu_En", {31'd0, alu_En}, 32'h0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst release cmd_ready", {31'd0, bus.cmd_ready}, 32'h1);
      check("arst release busy", {31'd0, busy}, 32'h0);
      repeat (25) @(posedge clk);
      #1;
      check("arst no stale rsp", {31'd0, bus.rsp_valid}, 32'h0);
      run_cmd(tbl[0], d, c, lat, nrst, nl, nen, s_ok);
      check("arst next data", {24'd0, d}, 32'h11);
      check("arst next cout", {31'd0, c}, 32'h1);
      ack();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side initiator for the 8-bit ALU. It accepts one operation request over a valid/ready handshake and drives the ALU control and operand pins (a, b, L, En, reset, s) cycle by cycle.
- It samples the ALU outputs f/cout at a defined cycle and returns the result over a second valid/ready handshake.
- It sits between a host/test controller and the ALU instance, on the same clock.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU data width.
- CNT_W, 8, width of the run-length field for shift/count operations.

Ports:
- clock  input  1  rising-edge clock, shared with the ALU.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
- cmd_op  input  2  00 add, 01 shift, 10 count, 11 logic.
- cmd_a  input  WIDTH  operand A, serial-in source, or counter load value.
- cmd_b  input  WIDTH  operand B.
- cmd_cin  input  1  adder carry-in.
- cmd_clr  input  1  pulse ALU reset before a shift/count operation.
- cmd_len  input  CNT_W  number of RUN cycles for shift/count.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_L  output  1  to ALU L (carry-in / counter load).
- alu_En  output  1  to ALU En.
- alu_reset  output  1  to ALU reset, active-low.
- alu_s  output  2  to ALU s.
- alu_f  input  WIDTH  from ALU f.
- alu_cout  input  1  from ALU cout.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  host accepts result.
- rsp_data  output  WIDTH  captured f.
- rsp_cout  output  1  captured cout; forced 0 for ops other than add.
- busy  output  1  high in any state except IDLE.

Behaviour:
- States: IDLE, CLEAR, LOAD, RUN, CAPTURE, RESP. State and all registered outputs use the asynchronous reset.
- Reset values: state IDLE; alu_a/alu_b 0; alu_L 0; alu_En 0; alu_s 00; rsp_valid 0; rsp_data 0; rsp_cout 0; busy 0.
- alu_reset = reset AND (state != CLEAR). The ALU is therefore held in reset whenever the sequencer is reset.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register all cmd_* fields. Next state:
  - add/logic: CAPTURE.
  - shift/count: CLEAR if cmd_clr, else LOAD for count, RUN for shift.
- From acceptance through CAPTURE, alu_a=cmd_a, alu_b=cmd_b and alu_s=cmd_op are held constant.
- CLEAR (1 cycle): alu_reset low. Next state is LOAD for count, RUN for shift.
- LOAD (count only, 1 cycle): alu_L=1, alu_En=1. The counter holds cmd_a after this edge. Next state is RUN.
- RUN: alu_L=0. alu_En=1 for count, 0 for shift. The cycle counter is loaded with cmd_len and decrements; state lasts exactly cmd_len cycles. If cmd_len=0, RUN is skipped and the FSM goes straight to CAPTURE.
- CAPTURE (1 cycle):
  - add: alu_L=cmd_cin.
  - count: alu_En=0, alu_L=0.
  - At the end of this cycle, rsp_data<=alu_f and rsp_cout<=alu_cout (add) or 0 (other ops). rsp_valid<=1. Next state is RESP.
- RESP: hold rsp_* stable until rsp_valid&rsp_ready, then rsp_valid<=0 and return to IDLE. No new command is accepted until that cycle has passed.
- Latency from command accept edge to rsp_valid:
  - add/logic: 2 edges.
  - count: 3 + cmd_len + cmd_clr edges.
  - shift: 2 + cmd_len + cmd_clr edges.
- Count arithmetic: result = (cmd_a + cmd_len) mod 2^WIDTH; it wraps with no flag.
- Add: rsp_data = (a+b+cin) mod 256, rsp_cout = carry out of bit 7.
- cmd_valid while busy is ignored; no queuing.
- reset asserted mid-operation: FSM returns to IDLE immediately, rsp_valid drops, the in-flight command is lost and alu_reset goes low.

Test Plan:
- Add: a=8'hF0, b=8'h20, cin=1 -> rsp_data=8'h11, rsp_cout=1; rsp_valid exactly 2 edges after accept; alu_s=00 throughout.
- Count wrap: a=8'hFE, len=5, clr=1, op=10 -> alu_reset low exactly 1 cycle, alu_L high exactly 1 cycle, alu_En high 6 cycles; rsp_data=8'h03, rsp_cout=0, latency 9 edges.
- Zero-length count: a=8'h5A, len=0, clr=0 -> RUN skipped, rsp_data=8'h5A after 3 edges.
- Back-pressure: any command with rsp_ready held low for 10 cycles -> rsp_valid/rsp_data stable; cmd_ready=0; second cmd_valid ignored. Release -> return to IDLE; next command accepted the following cycle.
- Shift: op=01, clr=1, len=4 -> alu_s=01, alu_reset low 1 cycle, RUN 4 cycles with alu_En=0; rsp_data equals alu_f sampled in CAPTURE; rsp_cout=0.
- Async reset mid-RUN of a count with len=20 -> busy/rsp_valid go 0 and alu_reset goes 0 without waiting for a clock; after release, cmd_ready=1.
